// File: rtl/implication_monitor_if.sv
// Bundles the control inputs and result/statistics outputs of implication_monitor.
// The master side drives the stimulus and the slave side is the monitor.
interface implication_monitor_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             trig;
  logic             a;
  logic             b;
  logic             clr_cnt;
  logic             busy;
  logic             pass_o;
  logic [CNT_W-1:0] pass_tag;
  logic             fail_a_o;
  logic             fail_b_o;
  logic [CNT_W-1:0] fail_b_tag;
  logic [CNT_W-1:0] attempt_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output en, trig, a, b, clr_cnt,
    input  busy, pass_o, pass_tag, fail_a_o, fail_b_o, fail_b_tag,
    input  attempt_cnt, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, trig, a, b, clr_cnt,
    output busy, pass_o, pass_tag, fail_a_o, fail_b_o, fail_b_tag,
    output attempt_cnt, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/implication_monitor.sv
// Checks "trig |-> a ##DELAY b": each start edge checks a immediately and b DELAY
// edges later, with up to DELAY attempts in flight, plus saturating statistics.
module implication_monitor #(
  parameter int DELAY = 2,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  implication_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q;
  logic [DELAY-1:0] vld_q, vld_d;
  logic [CNT_W-1:0] ts_q [DELAY];

  logic             start, enq, exit_vld, pending;
  logic [CNT_W-1:0] exit_ts;

  logic             pass_q, pass_d, fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [CNT_W-1:0] pass_tag_q, pass_tag_d, fail_b_tag_q, fail_b_tag_d;
  logic [CNT_W-1:0] att_cnt_q, att_cnt_d, pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

  // Attempts start only while running and still enabled; en=0 in RUN already stops intake.
  assign start    = (state_q == RUN) && mon.en && mon.trig;
  assign enq      = start && mon.a;
  assign exit_vld = vld_q[DELAY-1];
  assign exit_ts  = ts_q[DELAY-1];
  assign pending  = |vld_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mon.en) state_d = RUN;
      RUN:     if (!mon.en) state_d = DRAIN;
      DRAIN: begin
        if (mon.en)        state_d = RUN;
        else if (!pending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d        = vld_q << 1;
    vld_d[0]     = enq;
    pass_d       = exit_vld && mon.b;
    fail_b_d     = exit_vld && !mon.b;
    fail_a_d     = start && !mon.a;
    pass_tag_d   = pass_d   ? exit_ts : pass_tag_q;
    fail_b_tag_d = fail_b_d ? exit_ts : fail_b_tag_q;
    // Counters advance on the same edge that launches the matching pulse.
    att_cnt_d    = mon.clr_cnt ? '0 : sat_add(att_cnt_q,  {1'b0, start});
    pass_cnt_d   = mon.clr_cnt ? '0 : sat_add(pass_cnt_q, {1'b0, pass_d});
    fail_cnt_d   = mon.clr_cnt ? '0 :
                   sat_add(fail_cnt_q, {1'b0, fail_a_d} + {1'b0, fail_b_d});
  end

  // Stage boundary: control, result pulses, tags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      vld_q        <= '0;
      pass_q       <= 1'b0;
      fail_a_q     <= 1'b0;
      fail_b_q     <= 1'b0;
      pass_tag_q   <= '0;
      fail_b_tag_q <= '0;
      att_cnt_q    <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_q + 1'b1;
      vld_q        <= vld_d;
      pass_q       <= pass_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      pass_tag_q   <= pass_tag_d;
      fail_b_tag_q <= fail_b_tag_d;
      att_cnt_q    <= att_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  // Stage boundary: timestamp shift line, qualified by vld_q so it needs no reset.
  always_ff @(posedge clk) begin
    ts_q[0] <= cyc_q;
    for (int k = 1; k < DELAY; k++) ts_q[k] <= ts_q[k-1];
  end

  assign mon.busy        = (state_q != IDLE);
  assign mon.pass_o      = pass_q;
  assign mon.pass_tag    = pass_tag_q;
  assign mon.fail_a_o    = fail_a_q;
  assign mon.fail_b_o    = fail_b_q;
  assign mon.fail_b_tag  = fail_b_tag_q;
  assign mon.attempt_cnt = att_cnt_q;
  assign mon.pass_cnt    = pass_cnt_q;
  assign mon.fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_implication_monitor.sv
// Bench for implication_monitor: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_implication_monitor;
  localparam int DELAY = 2;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  implication_monitor_if #(.CNT_W(CNT_W)) mon();

  implication_monitor #(.DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending attempts live in a queue with an absolute due cycle.
  typedef struct {
    int ts;
    int due;
  } att_t;

  att_t pend[$];
  att_t hd, nw;
  int   m_n, m_mode;          // mode: 0 idle, 1 running, 2 draining
  int   m_busy, m_pass, m_fa, m_fb, m_ptag, m_ftag, m_att, m_pc, m_fc;
  bit   st, had;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      m_n = 0; m_mode = 0; m_busy = 0;
      m_pass = 0; m_fa = 0; m_fb = 0; m_ptag = 0; m_ftag = 0;
      m_att = 0; m_pc = 0; m_fc = 0;
    end else begin
      had = (pend.size() > 0);
      st  = (m_mode == 1) && mon.en && mon.trig;
      m_pass = 0;
      m_fb   = 0;
      if (had && pend[0].due == m_n) begin
        hd = pend.pop_front();
        if (mon.b) begin m_pass = 1; m_ptag = hd.ts; end
        else       begin m_fb   = 1; m_ftag = hd.ts; end
      end
      m_fa = (st && !mon.a) ? 1 : 0;
      if (st && mon.a) begin
        nw.ts  = m_n % (MAXC + 1);
        nw.due = m_n + DELAY;
        pend.push_back(nw);
      end
      if (mon.clr_cnt) begin
        m_att = 0; m_pc = 0; m_fc = 0;
      end else begin
        m_att = sat(m_att + (st ? 1 : 0));
        m_pc  = sat(m_pc + m_pass);
        m_fc  = sat(m_fc + m_fa + m_fb);
      end
      if (m_mode == 0)      m_mode = mon.en ? 1 : 0;
      else if (m_mode == 1) m_mode = mon.en ? 1 : 2;
      else                  m_mode = mon.en ? 1 : (had ? 2 : 0);
      m_busy = (m_mode != 0) ? 1 : 0;
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",        mon.busy,        m_busy);
      chk("pass_o",      mon.pass_o,      m_pass);
      chk("fail_a_o",    mon.fail_a_o,    m_fa);
      chk("fail_b_o",    mon.fail_b_o,    m_fb);
      chk("pass_tag",    mon.pass_tag,    m_ptag);
      chk("fail_b_tag",  mon.fail_b_tag,  m_ftag);
      chk("attempt_cnt", mon.attempt_cnt, m_att);
      chk("pass_cnt",    mon.pass_cnt,    m_pc);
      chk("fail_cnt",    mon.fail_cnt,    m_fc);
    end
  end

  task automatic drv(input logic e, input logic t, input logic aa,
                     input logic bb, input logic cc);
    mon.en = e; mon.trig = t; mon.a = aa; mon.b = bb; mon.clr_cnt = cc;
  endtask

  // Leaves the caller at negedge+1 of cycle 0 (cyc == 0, state IDLE).
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic en_r;

  initial begin
    drv(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("lit_rst_busy",     mon.busy,       0);
    chk("lit_rst_pass_tag", mon.pass_tag,   0);
    chk("lit_rst_fbtag",    mon.fail_b_tag, 0);
    chk("lit_rst_fail_cnt", mon.fail_cnt,   0);

    // Immediate a-failure at cycle 5, then a pass started at cycle 10.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0)  chk("litA_idle_busy", mon.busy, 0);
      if (c == 1)  chk("litA_run_busy",  mon.busy, 1);
      if (c == 6)  begin
        chk("litA_fail_a", mon.fail_a_o, 1);
        chk("litA_fcnt",   mon.fail_cnt, 1);
        chk("litA_acnt",   mon.attempt_cnt, 1);
      end
      if (c == 7)  chk("litA_fail_a_gone", mon.fail_a_o, 0);
      if (c == 13) begin
        chk("litA_pass",  mon.pass_o,   1);
        chk("litA_ptag",  mon.pass_tag, 10);
        chk("litA_pcnt",  mon.pass_cnt, 1);
      end
      if (c == 14) begin
        chk("litA_pass_gone", mon.pass_o,   0);
        chk("litA_ptag_hold", mon.pass_tag, 10);
      end
      drv(1, (c == 5 || c == 10), (c == 10), (c == 12), 0);
    end

    // Back-to-back starts; b failures coincide with a failures.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 7) begin
        chk("litB_fb7",   mon.fail_b_o,   1);
        chk("litB_tag7",  mon.fail_b_tag, 4);
        chk("litB_fa7",   mon.fail_a_o,   1);
        chk("litB_fcnt7", mon.fail_cnt,   2);
      end
      if (c == 8) begin
        chk("litB_fb8",   mon.fail_b_o,   1);
        chk("litB_tag8",  mon.fail_b_tag, 5);
        chk("litB_fa8",   mon.fail_a_o,   1);
        chk("litB_fcnt8", mon.fail_cnt,   4);
      end
      if (c == 9) chk("litB_fb9", mon.fail_b_o, 0);
      if (c == 11) begin
        chk("litB_acnt", mon.attempt_cnt, 6);
        chk("litB_fcnt", mon.fail_cnt,    6);
        chk("litB_pcnt", mon.pass_cnt,    0);
      end
      drv(1, (c >= 4 && c <= 9), (c == 4 || c == 5), !(c == 6 || c == 7), 0);
    end

    // Drain: start at 3, en drops at 4, later triggers ignored.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) chk("litC_drain_busy", mon.busy, 1);
      if (c == 6) begin
        chk("litC_pass",  mon.pass_o,   1);
        chk("litC_ptag",  mon.pass_tag, 3);
        chk("litC_busy6", mon.busy,     1);
      end
      if (c == 7) chk("litC_busy7", mon.busy, 0);
      if (c == 10) chk("litC_acnt", mon.attempt_cnt, 1);
      drv((c <= 3), (c >= 3 && c <= 9), 1, 1, 0);
    end

    // Reset with two attempts in flight: nothing may ever be reported for them.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 9) begin
        chk("litD_acnt_rst", mon.attempt_cnt, 0);
        chk("litD_busy_rst", mon.busy,        0);
      end
      if (c >= 9 && c <= 13) begin
        chk("litD_no_pass",   mon.pass_o,   0);
        chk("litD_no_fail_b", mon.fail_b_o, 0);
      end
      if (c == 14) chk("litD_pcnt", mon.pass_cnt, 0);
      drv(1, (c == 6 || c == 7), 1, 1, 0);
      if (c == 8)  #1 rst_n = 1'b0;
      if (c == 10) #1 rst_n = 1'b1;
    end

    // Saturation of 4-bit counters, then clear on an edge that also fails.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 16) chk("litE_fcnt16", mon.fail_cnt, 15);
      if (c == 20) begin
        chk("litE_fcnt_sat", mon.fail_cnt,    15);
        chk("litE_acnt_sat", mon.attempt_cnt, 15);
      end
      if (c == 21) begin
        chk("litE_fcnt_clr", mon.fail_cnt,    0);
        chk("litE_acnt_clr", mon.attempt_cnt, 0);
        chk("litE_fa21",     mon.fail_a_o,    1);
      end
      if (c == 22) chk("litE_fcnt22", mon.fail_cnt, 1);
      drv(1, (c >= 1), 0, 0, (c == 20));
    end

    // Randomized traffic against the model.
    do_reset();
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        drv(0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      drv(en_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
